// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit accumulator machine.
// Optional single-step gating of instruction fetch is enabled by defining SEQ_STEP_EN.
module alu_sequencer #(
    parameter logic [4:0] RESET_PC  = 5'd0,
    parameter logic [7:0] ACC_RESET = 8'h00
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
`ifdef SEQ_STEP_EN
    input  logic       step_i,
`endif
    output logic       busy_o,
    output logic       halted_o,
    output logic       imem_req_o,
    output logic [4:0] imem_addr_o,
    input  logic       imem_ack_i,
    input  logic [7:0] imem_data_i,
    output logic [2:0] rf_raddr_o,
    input  logic [7:0] rf_rdata_i,
    output logic       rf_we_o,
    output logic [2:0] rf_waddr_o,
    output logic [7:0] rf_wdata_o,
    output logic [7:0] alu_a_o,
    output logic [7:0] alu_b_o,
    output logic [1:0] alu_ctrl_o,
    input  logic [7:0] alu_result_i,
    output logic [7:0] acc_o,
    output logic [4:0] pc_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        OpAdd,
        OpNand,
        OpBz,
        OpSlt,
        OpLda,
        OpSta,
        OpLdi,
        OpHalt
    } op_e;

    state_e     state_q, state_d;
    logic [4:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] opnd_q, opnd_d;
    logic       fetch_go;
    op_e        op;

    assign op = op_e'(ir_q[7:5]);

`ifdef SEQ_STEP_EN
    // Set by a step pulse seen in FETCH, consumed by the fetch handshake.
    logic armed_q, armed_d;

    assign fetch_go = armed_q;

    always_comb begin
        armed_d = armed_q;
        if (state_q == StFetch) begin
            if (armed_q && imem_ack_i) begin
                armed_d = 1'b0;
            end else if (!armed_q && step_i) begin
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        busy_o     = 1'b0;
        halted_o   = 1'b0;
        imem_req_o = 1'b0;
        rf_raddr_o = 3'd0;
        rf_we_o    = 1'b0;
        rf_waddr_o = 3'd0;
        alu_ctrl_o = 2'b00;

        unique case (state_q)
            StIdle, StHalt: begin
                halted_o = (state_q == StHalt);
                if (start_i) begin
                    state_d = StFetch;
                    pc_d    = RESET_PC;
                end
            end
            StFetch: begin
                busy_o     = 1'b1;
                imem_req_o = fetch_go;
                if (fetch_go && imem_ack_i) begin
                    ir_d    = imem_data_i;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                busy_o     = 1'b1;
                rf_raddr_o = ir_q[2:0];
                // BZ and LDI carry an immediate; everything else reads the register file.
                if (op == OpLdi || op == OpBz) begin
                    opnd_d = {3'b000, ir_q[4:0]};
                end else begin
                    opnd_d = rf_rdata_i;
                end
                state_d = StExec;
            end
            StExec: begin
                busy_o  = 1'b1;
                pc_d    = pc_q + 5'd1;
                state_d = StFetch;
                if (!ir_q[7]) begin
                    alu_ctrl_o = ir_q[6:5];
                end
                case (op)
                    OpAdd, OpNand, OpSlt: acc_d = alu_result_i;
                    OpBz: begin
                        if (acc_q == 8'h00) begin
                            pc_d = alu_result_i[4:0];
                        end
                    end
                    OpLda, OpLdi: acc_d = opnd_q;
                    OpSta: begin
                        rf_we_o    = 1'b1;
                        rf_waddr_o = ir_q[2:0];
                    end
                    OpHalt: begin
                        pc_d    = pc_q;
                        state_d = StHalt;
                    end
                    default: state_d = StFetch;
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            acc_q   <= ACC_RESET;
            opnd_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign acc_o       = acc_q;
    assign alu_a_o     = acc_q;
    assign alu_b_o     = opnd_q;
    assign rf_wdata_o  = acc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ISA-level model checked every cycle plus directed programs.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
`ifdef SEQ_STEP_EN
    logic       step = 1'b0;
`endif
    logic       busy, halted, imem_req, imem_ack, rf_we;
    logic [4:0] imem_addr, pc;
    logic [7:0] imem_data, rf_rdata, rf_wdata, alu_a, alu_b, alu_result, acc;
    logic [2:0] rf_raddr, rf_waddr;
    logic [1:0] alu_ctrl;

    logic [7:0] imem [32];
    logic [7:0] rf [8];
    int         ack_delay = 0;
    int         req_cnt = 0;
    bit         stray_en = 1'b0;

    // Model state
    logic [4:0] mpc;
    logic [7:0] macc;
    logic [7:0] mrf [8];
    bit         mrun;
    int         ph;
    logic [2:0] exp_op;
    logic [7:0] exp_a, exp_b;
    logic [1:0] exp_ctrl;
    bit         exp_we;
    logic [2:0] exp_wa;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];
    assign imem_ack  = imem_req ? (req_cnt >= ack_delay) : stray_en;
    assign rf_rdata  = rf[rf_raddr];
    assign alu_result = (alu_ctrl == 2'b00) ? alu_a + alu_b :
                        (alu_ctrl == 2'b01) ? ~(alu_a & alu_b) :
                        (alu_ctrl == 2'b10) ? {3'b000, alu_b[4:0]} :
                                              {7'd0, alu_a < alu_b};

    alu_sequencer dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
`ifdef SEQ_STEP_EN
        .step_i      (step),
`endif
        .busy_o      (busy),
        .halted_o    (halted),
        .imem_req_o  (imem_req),
        .imem_addr_o (imem_addr),
        .imem_ack_i  (imem_ack),
        .imem_data_i (imem_data),
        .rf_raddr_o  (rf_raddr),
        .rf_rdata_i  (rf_rdata),
        .rf_we_o     (rf_we),
        .rf_waddr_o  (rf_waddr),
        .rf_wdata_o  (rf_wdata),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_ctrl_o  (alu_ctrl),
        .alu_result_i(alu_result),
        .acc_o       (acc),
        .pc_o        (pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Retire one instruction architecturally and record what its EXEC cycle must show.
    task automatic model_exec();
        logic [7:0] iw;
        logic [2:0] op;
        logic [4:0] imm;
        logic [7:0] b;
        iw  = imem[mpc];
        op  = iw[7:5];
        imm = iw[4:0];
        b   = (op == 3'd2 || op == 3'd6) ? {3'b000, imm} : mrf[imm[2:0]];
        exp_op   = op;
        exp_a    = macc;
        exp_b    = b;
        exp_ctrl = (op < 3'd4) ? op[1:0] : 2'b00;
        exp_we   = (op == 3'd5);
        exp_wa   = imm[2:0];
        case (op)
            3'd0: macc = macc + b;
            3'd1: macc = ~(macc & b);
            3'd3: macc = (macc < b) ? 8'd1 : 8'd0;
            3'd4: macc = b;
            3'd5: mrf[imm[2:0]] = macc;
            3'd6: macc = b;
            default: ;
        endcase
        if (op == 3'd2) mpc = (exp_a == 8'h00) ? imm : mpc + 5'd1;
        else if (op != 3'd7) mpc = mpc + 5'd1;
    endtask

    task automatic compare_cycle();
        if (reset) begin
            mrun = 1'b0;
            ph   = 0;
            macc = 8'h00;
            return;
        end
        if (start && !mrun) begin
            mrun = 1'b1;
            mpc  = 5'd0;
            ph   = 0;
        end
        if (ph == 2) begin
            check("exec_alu_ctrl", 32'(alu_ctrl), 32'(exp_ctrl));
            check("exec_alu_a", 32'(alu_a), 32'(exp_a));
            check("exec_alu_b", 32'(alu_b), 32'(exp_b));
            check("exec_rf_we", 32'(rf_we), 32'(exp_we));
            if (exp_we) begin
                check("exec_rf_waddr", 32'(rf_waddr), 32'(exp_wa));
                check("exec_rf_wdata", 32'(rf_wdata), 32'(exp_a));
            end
            if (exp_op == 3'd7) mrun = 1'b0;
            ph = 0;
        end else begin
            check("rf_we_outside_sta", 32'(rf_we), 0);
            if (ph == 1) ph = 2;
        end
        if (imem_req) begin
            check("fetch_addr", 32'(imem_addr), 32'(mpc));
            check("fetch_acc", 32'(acc), 32'(macc));
            if (imem_ack) begin
                model_exec();
                ph = 1;
            end
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 32; i++) imem[i] = 8'hE0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_prog(input bit noise, output int n, output int rq);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n  = 0;
        rq = 0;
        while (!halted && n < 400) begin
            start = noise && (n % 3 == 1);
            if (imem_req) rq++;
            @(posedge clk);
            #1 start = 1'b0;
            n++;
        end
        check("run_reaches_halt", 32'(halted), 1);
    endtask

    initial begin
        int n, rq;
        for (int i = 0; i < 8; i++) rf[i] = 8'h10 + 8'(i);
        rf[2] = 8'h02;
        rf[3] = 8'hFF;
        for (int i = 0; i < 8; i++) mrf[i] = rf[i];
        mrun = 1'b0;
        ph   = 0;
        macc = 8'h00;
        mpc  = 5'd0;
        clear_imem();

        fork
            forever begin
                @(posedge clk);
                req_cnt <= imem_req ? req_cnt + 1 : 0;
                if (rf_we) rf[rf_waddr] <= rf_wdata;
            end
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Reset values
        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_acc", 32'(acc), 0);
        check("rst_rf_raddr", 32'(rf_raddr), 0);
        check("rst_rf_waddr", 32'(rf_waddr), 0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 0);
        check("rst_opnd", 32'(alu_b), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // LDI 5; STA r1; LDI 3; ADD r1; HALT with zero-wait acks
        imem[0] = 8'hC5;
        imem[1] = 8'hA1;
        imem[2] = 8'hC3;
        imem[3] = 8'h01;
        imem[4] = 8'hE0;
        run_prog(1'b0, n, rq);
        check("p1_acc", 32'(acc), 'h08);
        check("p1_r1", 32'(rf[1]), 'h05);
        check("p1_pc", 32'(pc), 4);
        check("p1_cycles", 32'(n), 15);
        check("p1_busy", 32'(busy), 0);

        // Restart from HALT, then reset while the fetch is outstanding
        ack_delay = 10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("restart_req", 32'(imem_req), 1);
        check("restart_acc_kept", 32'(acc), 'h08);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midfetch_req", 32'(imem_req), 0);
        check("midfetch_busy", 32'(busy), 0);
        check("midfetch_halted", 32'(halted), 0);
        check("midfetch_pc", 32'(pc), 0);
        check("midfetch_acc", 32'(acc), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        stray_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("stray_ack_idle_busy", 32'(busy), 0);
        check("stray_ack_idle_pc", 32'(pc), 0);
        check("stray_ack_idle_acc", 32'(acc), 0);
        stray_en  = 1'b0;
        ack_delay = 0;

        // Branch taken on acc==0, not taken on acc!=0
        clear_imem();
        imem[0]  = 8'hC0;
        imem[1]  = 8'h4C;
        imem[12] = 8'hC7;
        imem[13] = 8'h4C;
        run_prog(1'b0, n, rq);
        check("bz_pc", 32'(pc), 14);
        check("bz_acc", 32'(acc), 'h07);

        // PC wrap at 31 and ADD wrap mod 256
        do_reset();
        clear_imem();
        imem[0]  = 8'h5E;
        imem[30] = 8'hDF;
        imem[31] = 8'hDF;
        imem[1]  = 8'h83;
        imem[2]  = 8'h02;
        run_prog(1'b0, n, rq);
        check("wrap_acc", 32'(acc), 'h01);
        check("wrap_pc", 32'(pc), 3);

        // Four-cycle ack latency with start noise and stray acks while busy
        do_reset();
        clear_imem();
        imem[0] = 8'hC5;
        imem[1] = 8'hA1;
        imem[2] = 8'hC3;
        imem[3] = 8'h01;
        ack_delay = 4;
        stray_en  = 1'b1;
        run_prog(1'b1, n, rq);
        stray_en  = 1'b0;
        ack_delay = 0;
        check("slow_req_cycles", 32'(rq), 25);
        check("slow_cycles", 32'(n), 35);
        check("slow_acc", 32'(acc), 'h08);
        check("slow_pc", 32'(pc), 4);

`ifdef SEQ_STEP_EN
        do_reset();
        clear_imem();
        imem[0] = 8'hC9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("step_no_req", 32'(imem_req), 0);
            @(posedge clk);
            #1;
        end
        check("step_wait_busy", 32'(busy), 1);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("step_one_pc", 32'(pc), 1);
        check("step_one_acc", 32'(acc), 'h09);
        check("step_one_req", 32'(imem_req), 0);
        check("step_one_halted", 32'(halted), 0);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        n = 0;
        while (!halted && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("step_two_halted", 32'(halted), 1);
        check("step_two_pc", 32'(pc), 1);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
